game_sequencer: RTL

//  Top-level FSM for the two-player black/white code-guessing game. Drives the 3-bit display state
//  and the round, win, lose, matchresult and gameresult values consumed by the display selector.

---
 rtl/game_pkg.sv | 47 ++++
 rtl/hold_timer.sv | 35 +++
 rtl/game_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: state encodings, result codes and small helpers shared by the
// code-guessing game sequencer and its sub-modules.
package game_pkg;

    typedef enum logic [2:0] {
        ST_INIT        = 3'b000,
        ST_RASP        = 3'b001,
        ST_BAWP        = 3'b010,
        ST_P1_TURN     = 3'b011,
        ST_P2_TURN     = 3'b100,
        ST_MATCHRESULT = 3'b101,
        ST_GAMERESULT  = 3'b110,
        ST_ILLEGAL     = 3'b111
    } state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Black count that means the secret code was fully guessed.
    localparam logic [3:0] SOLVED_BLACK = 4'd4;

    function automatic int max_int(input int a, input int b);
        int larger;
        if (a > b) begin
            larger = a;
        end else begin
            larger = b;
        end
        return larger;
    endfunction

    // Final verdict from the two match-win tallies.
    function automatic logic [1:0] game_verdict(input logic [3:0] p1_wins, input logic [3:0] p2_wins);
        logic [1:0] verdict;
        if (p1_wins > p2_wins) begin
            verdict = RES_P1;
        end else if (p2_wins > p1_wins) begin
            verdict = RES_P2;
        end else begin
            verdict = RES_DRAW;
        end
        return verdict;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: down-counter that measures a fixed interval of `length` cycles.
// `load` starts an interval (in the cycle that enters the timed state); `done`
// is high during the last cycle of the interval while `tick` is held.
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] length,
    input  logic             tick,
    output logic             done
);
    import game_pkg::*;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Load length-1 so the interval is exactly `length` cycles; count down while ticking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= length - ONE;
        end else if (tick && (count_r != '0)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level FSM of the two-player black/white guessing game.
// Sequences start screen, turns, black/white print, match result and game end,
// and drives the registered display state and score values.
// Optional feature: define GAME_TURN_TIMEOUT_EN to forfeit a turn after
// TURN_CYCLES idle cycles (a second hold_timer is then built for turns).
module game_sequencer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int WIN_TARGET  = 3,
    parameter int MAX_ROUND   = 9,
    parameter int TURN_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_submit,
    input  logic       p2_submit,
    input  logic [3:0] p1_black,
    input  logic [3:0] p2_black,
    output logic [2:0] state,
    output logic [3:0] round,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic [1:0] matchresult,
    output logic [1:0] gameresult,
    output logic       cap_p1,
    output logic       cap_p2
);
    import game_pkg::*;

    localparam int TIMER_W = $clog2(max_int(HOLD_CYCLES, TURN_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] HOLD_LEN  = TIMER_W'(HOLD_CYCLES);
    localparam logic [3:0]         WIN_LIMIT = 4'(WIN_TARGET);
    localparam logic [3:0]         LAST_RND  = 4'(MAX_ROUND);

    state_t     state_r;
    state_t     state_next;
    logic [3:0] round_r;
    logic [3:0] win_r;
    logic [3:0] lose_r;
    logic [1:0] matchresult_r;
    logic [1:0] gameresult_r;
    logic       cap_p1_r;
    logic       cap_p2_r;
    logic       b1_r;
    logic       b2_r;

    // FSM event strobes (mutually exclusive, one state each)
    logic start_game;
    logic accept_p1;
    logic accept_p2;
    logic forfeit_p1;
    logic forfeit_p2;
    logic bawp_hit;
    logic bawp_miss;
    logic game_over;
    logic next_match;

    logic in_hold;
    logic hold_load;
    logic hold_done;
    logic game_end;
    logic turn_expired;

    assign in_hold = (state_r == ST_RASP) || (state_r == ST_BAWP) || (state_r == ST_MATCHRESULT);

    // A hold interval starts whenever the FSM moves into a hold state from a different state.
    assign hold_load = ((state_next == ST_RASP) || (state_next == ST_BAWP) ||
                        (state_next == ST_MATCHRESULT)) && (state_next != state_r);

    assign game_end = (win_r == WIN_LIMIT) || (lose_r == WIN_LIMIT) || (round_r == LAST_RND);

    hold_timer #(.WIDTH(TIMER_W)) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .length (HOLD_LEN),
        .tick   (in_hold),
        .done   (hold_done)
    );

`ifdef GAME_TURN_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TURN_LEN = TIMER_W'(TURN_CYCLES);

    logic in_turn;
    logic turn_load;

    assign in_turn   = (state_r == ST_P1_TURN) || (state_r == ST_P2_TURN);
    assign turn_load = ((state_next == ST_P1_TURN) || (state_next == ST_P2_TURN)) &&
                       (state_next != state_r);

    hold_timer #(.WIDTH(TIMER_W)) u_turn_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (turn_load),
        .length (TURN_LEN),
        .tick   (in_turn),
        .done   (turn_expired)
    );
`else
    assign turn_expired = 1'b0;
`endif

    // State register; an illegal encoding is steered back to INIT by the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic and event strobes; a submit always beats a same-cycle turn timeout.
    always_comb begin
        state_next = state_r;
        start_game = 1'b0;
        accept_p1  = 1'b0;
        accept_p2  = 1'b0;
        forfeit_p1 = 1'b0;
        forfeit_p2 = 1'b0;
        bawp_hit   = 1'b0;
        bawp_miss  = 1'b0;
        game_over  = 1'b0;
        next_match = 1'b0;
        case (state_r)
            ST_INIT, ST_GAMERESULT: begin
                if (start) begin
                    start_game = 1'b1;
                    state_next = ST_RASP;
                end else begin
                    state_next = state_r;
                end
            end
            ST_RASP: begin
                if (hold_done) begin
                    state_next = ST_P1_TURN;
                end else begin
                    state_next = ST_RASP;
                end
            end
            ST_P1_TURN: begin
                if (p1_submit) begin
                    accept_p1  = 1'b1;
                    state_next = ST_P2_TURN;
                end else if (turn_expired) begin
                    forfeit_p1 = 1'b1;
                    state_next = ST_P2_TURN;
                end else begin
                    state_next = ST_P1_TURN;
                end
            end
            ST_P2_TURN: begin
                if (p2_submit) begin
                    accept_p2  = 1'b1;
                    state_next = ST_BAWP;
                end else if (turn_expired) begin
                    forfeit_p2 = 1'b1;
                    state_next = ST_BAWP;
                end else begin
                    state_next = ST_P2_TURN;
                end
            end
            ST_BAWP: begin
                if (!hold_done) begin
                    state_next = ST_BAWP;
                end else if (b1_r || b2_r) begin
                    bawp_hit   = 1'b1;
                    state_next = ST_MATCHRESULT;
                end else begin
                    bawp_miss  = 1'b1;
                    state_next = ST_P1_TURN;
                end
            end
            ST_MATCHRESULT: begin
                if (!hold_done) begin
                    state_next = ST_MATCHRESULT;
                end else if (game_end) begin
                    game_over  = 1'b1;
                    state_next = ST_GAMERESULT;
                end else begin
                    next_match = 1'b1;
                    state_next = ST_RASP;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Score, black latches and capture pulses, updated on the FSM event strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_r       <= 4'd0;
            win_r         <= 4'd0;
            lose_r        <= 4'd0;
            matchresult_r <= RES_NONE;
            gameresult_r  <= RES_NONE;
            b1_r          <= 1'b0;
            b2_r          <= 1'b0;
            cap_p1_r      <= 1'b0;
            cap_p2_r      <= 1'b0;
        end else begin
            cap_p1_r <= accept_p1;
            cap_p2_r <= accept_p2;
            if (start_game) begin
                round_r       <= 4'd1;
                win_r         <= 4'd0;
                lose_r        <= 4'd0;
                matchresult_r <= RES_NONE;
                gameresult_r  <= RES_NONE;
                b1_r          <= 1'b0;
                b2_r          <= 1'b0;
            end else if (accept_p1 || forfeit_p1) begin
                b1_r <= accept_p1 && (p1_black == SOLVED_BLACK);
            end else if (accept_p2 || forfeit_p2) begin
                b2_r <= accept_p2 && (p2_black == SOLVED_BLACK);
            end else if (bawp_miss) begin
                b1_r <= 1'b0;
                b2_r <= 1'b0;
            end else if (bawp_hit) begin
                matchresult_r <= {b2_r, b1_r};
                if (b1_r && !b2_r && (win_r < WIN_LIMIT)) begin
                    win_r <= win_r + 4'd1;
                end else begin
                    win_r <= win_r;
                end
                if (b2_r && !b1_r && (lose_r < WIN_LIMIT)) begin
                    lose_r <= lose_r + 4'd1;
                end else begin
                    lose_r <= lose_r;
                end
            end else if (game_over) begin
                gameresult_r <= game_verdict(win_r, lose_r);
            end else if (next_match) begin
                if (round_r < LAST_RND) begin
                    round_r <= round_r + 4'd1;
                end else begin
                    round_r <= round_r;
                end
                matchresult_r <= RES_NONE;
                b1_r          <= 1'b0;
                b2_r          <= 1'b0;
            end else begin
                round_r <= round_r;
            end
        end
    end

    assign state       = state_r;
    assign round       = round_r;
    assign win         = win_r;
    assign lose        = lose_r;
    assign matchresult = matchresult_r;
    assign gameresult  = gameresult_r;
    assign cap_p1      = cap_p1_r;
    assign cap_p2      = cap_p2_r;

endmodule
